usb_byte_receiver: RTL

// - Receive-side counterpart of the USB byte transmit path. Samples d_plus/d_minus
//   and decodes NRZI. Removes stuffed bits, detects SYNC and EOP, and assembles
//   LSB-first bytes for the RX packet FSM / FIFO.
// - Full-speed line, one system clock, CLKS_PER_BIT clocks per bit, same as the TX timer.

---
 rtl/usb_byte_receiver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/usb_byte_receiver.sv
// usb_byte_receiver: full-speed USB receive path (line sync, bit timing, NRZI decode, unstuffing, SYNC/EOP detect, byte assembly)
// Optional CRC16 check on the data payload is built when RX_CRC16_EN is defined; otherwise crc_ok is tied low.
module usb_byte_receiver #(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       sync_found,
  output logic       eop,
  output logic       rx_active,
  output logic       stuff_err,
  output logic       align_err,
  output logic [7:0] byte_count,
  output logic       crc_ok
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [PW-1:0] SAMPLE_PH = PW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP_WAIT, ERROR} state_t;
  state_t state, state_n;
  logic [1:0] meta, line, prev_line;
  logic dp_last;
  logic [PW-1:0] phase;
  logic [7:0] sr, sr_n, shifted, rx_byte_n, byte_count_n;
  logic [2:0] bit_cnt, bit_cnt_n, ones, ones_n;
  logic [IW-1:0] j_cnt, j_cnt_n;
  logic se0_seen, se0_seen_n;
  logic byte_valid_n, sync_found_n, eop_n, stuff_err_n, align_err_n, crc_ok_n;
  logic sample, is_se0, is_j, is_k, dbit, data_strobe;
  assign sample    = phase == SAMPLE_PH;
  assign is_se0    = line == SE0;
  assign is_j      = line == J;
  assign is_k      = line == K;
  assign dbit      = line == prev_line;
  assign shifted   = {dbit, sr[7:1]};
  assign rx_active = state == RECEIVE || state == EOP_WAIT;
  // Line front end: the phase counter re-centres on every D+ edge so mid-bit sampling tracks the sender.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      meta      <= J;
      line      <= J;
      dp_last   <= 1'b1;
      phase     <= '0;
      prev_line <= J;
    end else begin
      meta      <= {d_plus, d_minus};
      line      <= meta;
      dp_last   <= line[1];
      phase     <= (line[1] != dp_last || phase == LAST_PH) ? '0 : phase + PW'(1);
      prev_line <= sample ? line : prev_line;
    end
  always_comb begin
    state_n      = state;
    sr_n         = sr;
    bit_cnt_n    = bit_cnt;
    ones_n       = ones;
    j_cnt_n      = state == ERROR ? j_cnt : '0;
    se0_seen_n   = state == ERROR && se0_seen;
    rx_byte_n    = rx_byte;
    byte_count_n = byte_count;
    byte_valid_n = 1'b0;
    sync_found_n = 1'b0;
    eop_n        = 1'b0;
    stuff_err_n  = 1'b0;
    align_err_n  = 1'b0;
    data_strobe  = 1'b0;
    if (sample)
      case (state)
        IDLE:
          if (is_k) begin
            // The K that leaves IDLE is the first SYNC bit (a decoded 0).
            state_n   = SYNC;
            sr_n      = '0;
            bit_cnt_n = 3'd1;
            ones_n    = '0;
          end
        SYNC, RECEIVE:
          if (is_se0) begin
            state_n     = state == SYNC ? ERROR : EOP_WAIT;
            se0_seen_n  = state == SYNC;
            align_err_n = state == RECEIVE && bit_cnt != 3'd0;
          end else if (ones == 3'd6) begin
            ones_n = '0;
            if (dbit) begin
              stuff_err_n = 1'b1;
              state_n     = ERROR;
            end
          end else begin
            data_strobe = 1'b1;
            ones_n      = dbit ? ones + 3'd1 : '0;
            sr_n        = shifted;
            bit_cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == SYNC) begin
                state_n = shifted == 8'h80 ? RECEIVE : ERROR;
                if (shifted == 8'h80) begin
                  sync_found_n = 1'b1;
                  byte_count_n = '0;
                end
              end else begin
                rx_byte_n    = shifted;
                byte_valid_n = 1'b1;
                byte_count_n = byte_count + {7'd0, byte_count != 8'hFF};
              end
            end
          end
        EOP_WAIT:
          if (is_j) begin
            eop_n   = 1'b1;
            state_n = IDLE;
          end else if (is_k) begin
            state_n = ERROR;
          end
        ERROR:
          if (is_se0) begin
            se0_seen_n = 1'b1;
            j_cnt_n    = '0;
          end else if (is_k) begin
            se0_seen_n = 1'b0;
            j_cnt_n    = '0;
          end else if (is_j) begin
            if (se0_seen || j_cnt == IW'(IDLE_BITS - 1)) state_n = IDLE;
            else j_cnt_n = j_cnt + IW'(1);
          end
        default: state_n = IDLE;
      endcase
    if (!rx_en) begin
      state_n      = IDLE;
      sr_n         = '0;
      bit_cnt_n    = '0;
      ones_n       = '0;
      j_cnt_n      = '0;
      se0_seen_n   = 1'b0;
      byte_count_n = '0;
      byte_valid_n = 1'b0;
      sync_found_n = 1'b0;
      eop_n        = 1'b0;
      stuff_err_n  = 1'b0;
      align_err_n  = 1'b0;
      data_strobe  = 1'b0;
    end
  end
`ifdef RX_CRC16_EN
  logic [15:0] crc, crc_n;
  // Covers every data bit after the PID; the final value checked at EOP is the fixed residual.
  always_comb begin
    crc_n = crc;
    if (!rx_en || sync_found_n) crc_n = 16'hFFFF;
    else if (data_strobe && state == RECEIVE && byte_count != 8'd0)
      crc_n = {crc[14:0], 1'b0} ^ ({16{crc[15] ^ dbit}} & 16'h8005);
  end
  assign crc_ok_n = eop_n && crc == 16'h800D;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc <= 16'hFFFF;
    else crc <= crc_n;
`else
  assign crc_ok_n = 1'b0;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      ones       <= '0;
      j_cnt      <= '0;
      se0_seen   <= 1'b0;
      rx_byte    <= '0;
      byte_count <= '0;
      byte_valid <= 1'b0;
      sync_found <= 1'b0;
      eop        <= 1'b0;
      stuff_err  <= 1'b0;
      align_err  <= 1'b0;
      crc_ok     <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= bit_cnt_n;
      ones       <= ones_n;
      j_cnt      <= j_cnt_n;
      se0_seen   <= se0_seen_n;
      rx_byte    <= rx_byte_n;
      byte_count <= byte_count_n;
      byte_valid <= byte_valid_n;
      sync_found <= sync_found_n;
      eop        <= eop_n;
      stuff_err  <= stuff_err_n;
      align_err  <= align_err_n;
      crc_ok     <= crc_ok_n;
    end
endmodule
